cpu_run_ctrl: RTL
=================

// Module: cpu_run_ctrl
// PURPOSE
//  Synthesizable run controller that sequences CPU reset and stall.
//  Sits between the bench/top and the CPU core (sccpu or successors).
//  Holds the core in reset for a set number of cycles, then drives per-channel stall.
//  Stall modes: none, periodic, LFSR-random, single-step. Counts cycles and stall cycles.
//  Ends the run on halt request or timeout.
// PARAMETERS
//  NCH        1         number of stall channels (e.g. one per pipeline stage)
//  CNT_W      32        width of cycle/stall counters
//  PERIOD_W   8         width of period/duty fields
//  RST_CYCLES 1         cycles cpu_rst is held after entering RESET (>=1)
//  MAX_CYCLES 100000    RUN cycles before timeout (>=1)
//  LFSR_SEED  16'hACE1  base seed; channel i uses LFSR_SEED ^ (16'h1D3B*(i+1)), never 0
// PORTS
//  clk        in   1         clock
//  rst        in   1         asynchronous active-low reset
//  start      in   1         pulse: begin run (accepted in IDLE or DONE)
//  mode       in   2         0 none, 1 periodic, 2 random, 3 single-step
//  period     in   PERIOD_W  periodic-mode period in cycles
//  duty       in   PERIOD_W  periodic-mode stalled cycles per period
//  density    in   8         random-mode stall threshold (out of 256)
//  step_req   in   1         single-step pulse: release stall for one cycle
//  halt_req   in   1         CPU reports halt; ends run
//  cpu_rst    out  1         active-high reset to CPU core
//  stall      out  NCH       stall to CPU core, one bit per channel
//  cycle_cnt  out  CNT_W     RUN cycles elapsed
//  stall_cnt  out  CNT_W     RUN cycles with stall[0]=1
//  running    out  1         state==RUN
//  done       out  1         run finished (halt or timeout)
//  timeout    out  1         run ended by MAX_CYCLES
// BEHAVIOUR
//  Reset (rst=0, async, at any time incl. mid-run):
//   state=IDLE, cpu_rst=1, stall='1, counters=0, running=done=timeout=0, LFSRs=seeds.
//  FSM: IDLE -start-> RESET -RST_CYCLES elapsed-> RUN -halt|timeout-> DONE -start-> RESET.
//  RESET: cpu_rst=1, stall='1; counters, done and timeout cleared on entry.
//   mode/period/duty/density latched on the RESET->RUN transition; changes during RUN are ignored.
//  RUN: cpu_rst=0; cycle_cnt+1 every cycle; stall_cnt+1 when stall[0]=1. Both saturate at all-ones.
//  DONE: cpu_rst=0, stall='1 (core frozen), counters hold, done=1.
//   start in DONE restarts via RESET.
//  All outputs are registered. stall for RUN cycle k is computed from state at cycle k-1.
//  mode 0: stall='0 throughout RUN.
//  mode 1: phase counter 0..P-1, P=max(period,1), restarts at 0 on RUN entry.
//   All channels stall while phase<duty. duty=0 -> never; duty>=P -> always.
//  mode 2: per-channel 16-bit Galois LFSR (taps 16,14,13,11), advanced every RUN cycle.
//   stall[i]=(lfsr_i[7:0]<density). density=0 -> never.
//  mode 3: stall='1 by default; step_req in RUN drops stall to '0 for exactly the next cycle.
//   step_req while already released is not queued. Only one release per pulse.
//  Termination: halt_req in RUN -> DONE next cycle, timeout=0.
//   cycle_cnt reaching MAX_CYCLES -> DONE, timeout=1.
//   halt_req and timeout in the same cycle: halt wins, timeout=0.
//  start while RESET or RUN is ignored. halt_req outside RUN is ignored.
// TESTING
//  1 Async rst low mid-RUN -> cpu_rst=1, stall='1, cycle_cnt=0, state IDLE, same cycle.
//  2 mode0, RST_CYCLES=3, start -> cpu_rst high exactly 3 cycles, then stall=0.
//    halt_req at cycle_cnt=10 -> done=1, cycle_cnt=11, stall_cnt=0.
//  3 mode1 period=4 duty=1, 40 RUN cycles -> stall pattern 1000 repeating, stall_cnt=10.
//    Also period=0 duty=1 -> always stalled.
//  4 mode2 density=0 -> stall_cnt=0. density=128, 4096 cycles -> stall_cnt in [1900,2200].
//    Channels differ (NCH=2).
//  5 mode3, three step_req pulses -> exactly 3 cycles with stall=0.
//    Back-to-back step_req -> single release.
//  6 MAX_CYCLES=20, no halt -> done=1, timeout=1, cycle_cnt=20.
//    halt_req on timeout cycle -> timeout=0. start in DONE -> counters cleared, RESET re-entered.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller for a CPU core: holds the core in reset, then drives per-channel
// stall (none / periodic / LFSR-random / single-step) until halt or timeout.
module cpu_run_ctrl #(
    parameter int          NCH        = 1,
    parameter int          CNT_W      = 32,
    parameter int          PERIOD_W   = 8,
    parameter int          RST_CYCLES = 1,
    parameter int          MAX_CYCLES = 100000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic [PERIOD_W-1:0] duty,
    input  logic [7:0]          density,
    input  logic                step_req,
    input  logic                halt_req,
    output logic                cpu_rst,
    output logic [NCH-1:0]      stall,
    output logic [CNT_W-1:0]    cycle_cnt,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic                running,
    output logic                done,
    output logic                timeout
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RESET, S_RUN, S_DONE} state_e;
    typedef enum logic [1:0] {M_NONE, M_PERIODIC, M_RANDOM, M_STEP} mode_e;

    typedef struct packed {
        mode_e               mode;
        logic [PERIOD_W-1:0] period;
        logic [PERIOD_W-1:0] duty;
        logic [7:0]          density;
    } cfg_t;

    function automatic logic [15:0] seed_of(input int ch);
        logic [15:0] s;
        s = LFSR_SEED ^ 16'(32'h1D3B * (ch + 1));
        return (s == 16'h0) ? 16'h0001 : s;
    endfunction

    // Galois form, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    state_e                 state_q, state_d;
    logic [RC_W-1:0]        rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]       cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;
    logic [PERIOD_W-1:0]    phase_q, phase_d;
    logic [NCH-1:0][15:0]   lfsr_q, lfsr_d;
    cfg_t                   cfg_q, cfg_d;
    logic [NCH-1:0]         stall_q, stall_d;
    logic                   cpu_rst_q, cpu_rst_d;
    logic                   running_q, running_d;
    logic                   done_q, done_d;
    logic                   timeout_q, timeout_d;
    logic                   step_prev_q;

    logic                   enter_run;
    logic                   step_rise;
    logic [PERIOD_W-1:0]    period_eff;

    assign step_rise  = step_req & ~step_prev_q;
    assign period_eff = (cfg_d.period == '0) ? PERIOD_W'(1) : cfg_d.period;

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        phase_d     = phase_q;
        lfsr_d      = lfsr_q;
        cfg_d       = cfg_q;
        timeout_d   = timeout_q;
        stall_d     = '1;
        enter_run   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RESET;
                    rst_cnt_d   = '0;
                    cycle_cnt_d = '0;
                    stall_cnt_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    enter_run = 1'b1;
                    cfg_d     = '{mode: mode_e'(mode), period: period, duty: duty, density: density};
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + 1'b1;
                if (stall_q[0] && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
                if (halt_req) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (cycle_cnt_q == CNT_W'(MAX_CYCLES - 1)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Stall for the coming RUN cycle is decided here and registered.
        if (state_d == S_RUN) begin
            if (enter_run || phase_q >= period_eff - 1'b1) phase_d = '0;
            else                                           phase_d = phase_q + 1'b1;

            case (cfg_d.mode)
                M_NONE:     stall_d = '0;
                M_PERIODIC: stall_d = {NCH{phase_d < cfg_d.duty}};
                M_RANDOM: begin
                    for (int i = 0; i < NCH; i++) begin
                        lfsr_d[i]  = lfsr_step(lfsr_q[i]);
                        stall_d[i] = (lfsr_d[i][7:0] < cfg_d.density);
                    end
                end
                M_STEP:     stall_d = (!enter_run && step_rise && stall_q[0]) ? '0 : '1;
                default:    stall_d = '1;
            endcase
        end

        cpu_rst_d = (state_d == S_IDLE) || (state_d == S_RESET);
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            phase_q     <= '0;
            cfg_q       <= '0;
            stall_q     <= '1;
            cpu_rst_q   <= 1'b1;
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            step_prev_q <= 1'b0;
            for (int i = 0; i < NCH; i++) lfsr_q[i] <= seed_of(i);
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            phase_q     <= phase_d;
            cfg_q       <= cfg_d;
            lfsr_q      <= lfsr_d;
            stall_q     <= stall_d;
            cpu_rst_q   <= cpu_rst_d;
            running_q   <= running_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            step_prev_q <= step_req;
        end
    end

    assign cpu_rst   = cpu_rst_q;
    assign stall     = stall_q;
    assign cycle_cnt = cycle_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign running   = running_q;
    assign done      = done_q;
    assign timeout   = timeout_q;

endmodule
